des_key_schedule: RTL and testbench
===================================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-low reset; clears all state while low.
REQ-003 load  input  1  start pulse, asserted in the same cycle as the round counter's set.
REQ-004 key_in  input  64  DES key, bit 63 = FIPS bit 1; parity bits ignored; sampled only when load=1.
REQ-005 decrypt  input  1  0 = encryption key order, 1 = decryption key order; sampled only when load=1.
REQ-006 cnt_in  input  4  round counter value, 15 down to 0 during a run.
REQ-007 subkey  output  48  current round subkey, bit 47 = FIPS bit 1.
REQ-008 subkey_valid  output  1  high while subkey holds a valid round key.
REQ-009 round_idx  output  4  0-based round number of the current subkey (0..15).
REQ-010 last_key  output  1  high while subkey_valid=1 and round_idx=15.
REQ-011 sync_err  output  1  sticky flag: cnt_in disagreed with the internal round count.

Function
REQ-012 Block SHALL hold 28-bit C and D registers, 4-bit rnd register, a latched mode bit and a two-state FSM: IDLE, RUN.
REQ-013 PC-1 and PC-2 SHALL be the FIPS 46-3 tables; C = PC-1 bits 1..28, D = bits 29..56.
REQ-014 Encrypt left-rotate schedule for rounds 1..16 SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-015 On a clock edge with load=1, from any state: mode <= decrypt; rnd <= 0; state <= RUN; sync_err <= 0.
REQ-016 Same edge, encrypt: C,D <= PC-1(key_in) halves, each rotated left by 1.
REQ-017 Same edge, decrypt: C,D <= PC-1(key_in) halves, unrotated.
REQ-018 On an edge in RUN with load=0 and rnd<15: rnd <= rnd+1.
REQ-019 Same edge, encrypt: C and D rotate left by the schedule entry for round rnd+2.
REQ-020 Same edge, decrypt: C and D rotate right by the schedule entry for round 16-rnd.
REQ-021 On an edge in RUN with load=0 and rnd=15: state <= IDLE; C, D and rnd hold.
REQ-022 subkey SHALL be PC-2(C,D) when in RUN and 48'h0 when in IDLE (no extra register stage).
REQ-023 subkey_valid SHALL be 1 exactly in RUN; round_idx SHALL equal rnd.
REQ-024 Latency: load at edge T gives subkey K1 (encrypt) or K16 (decrypt) in cycle T+1.
REQ-025 One new key per cycle; the 16th key is shown in cycle T+16; subkey_valid is low from T+17.
REQ-026 Each round's subkey SHALL align with cnt_in = 15 - round_idx from a counter set at T.
REQ-027 sync_err SHALL set on any edge in RUN with load=0 where cnt_in != 15 - rnd.
REQ-028 Once set, sync_err holds until the next load or reset.
REQ-029 A load in RUN SHALL abort the current run and restart at round 0 with the new key and mode.
REQ-030 In IDLE with load=0, all registers SHALL hold and cnt_in SHALL be ignored.

Reset
REQ-031 While rst=0, all registers SHALL clear asynchronously: state=IDLE, C=D=0, rnd=0, mode=0, sync_err=0.
REQ-032 While rst=0, outputs SHALL be subkey=0, subkey_valid=0, round_idx=0, last_key=0.
REQ-033 Reset asserted mid-run SHALL abort the run; after release the block stays IDLE until load.
REQ-034 A load coincident with rst=0 SHALL be ignored.

Verification
REQ-035 Encrypt: key_in=64'h133457799BBCDFF1, decrypt=0, load with counter set -> T+1: subkey=48'h1B02EFFC7072, round_idx=0; T+16: subkey=48'hCB3D8B0E17F5, last_key=1; T+17: subkey_valid=0; sync_err stays 0.
REQ-036 Decrypt: same key, decrypt=1 -> T+1: subkey=48'hCB3D8B0E17F5; T+16: subkey=48'h1B02EFFC7072; all 16 keys equal the encrypt sequence reversed.
REQ-037 Restart: second load at T+5 with a new key -> T+6 shows K1 of the new key, round_idx=0; the run completes at T+21.
REQ-038 Desync: force cnt_in=7 at round_idx=3 -> sync_err=1 from the next cycle; the subkey sequence is unaffected; the next load clears sync_err.
REQ-039 Reset: drive rst low asynchronously at mid-run round 8 -> outputs 0 immediately; after release subkey_valid stays 0 until load.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key schedule: expands a 64-bit key into the sixteen 48-bit round
// subkeys, one per clock, in encryption or decryption order.  The round
// count is tracked internally and cross-checked against an external
// down-counter so a desynchronised datapath is flagged.
`timescale 1ns/1ps

module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic [3:0]  cnt_in,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_idx,
    output logic        last_key,
    output logic        sync_err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [27:0] c_q, d_q;
    logic [27:0] c_step, d_step;
    logic [27:0] pc1_c, pc1_d;
    logic [3:0]  rnd_q;
    logic        mode_q;
    logic        sync_q;
    logic [4:0]  enc_round, dec_round;
    logic        unused_parity;

    // Rotate a 28-bit half left by one or two places.
    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    // Rotate a 28-bit half right by one or two places.
    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Encrypt shift count for 1-based round r: one place in rounds 1, 2, 9
    // and 16, two places otherwise.
    function automatic logic sched_two(input logic [4:0] r);
        return !((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16));
    endfunction

    // PC-1: FIPS bit n of the key is key_in[64-n].
    assign pc1_c = {key_in[7],  key_in[15], key_in[23], key_in[31], key_in[39], key_in[47], key_in[55],
                    key_in[63], key_in[6],  key_in[14], key_in[22], key_in[30], key_in[38], key_in[46],
                    key_in[54], key_in[62], key_in[5],  key_in[13], key_in[21], key_in[29], key_in[37],
                    key_in[45], key_in[53], key_in[61], key_in[4],  key_in[12], key_in[20], key_in[28]};
    assign pc1_d = {key_in[1],  key_in[9],  key_in[17], key_in[25], key_in[33], key_in[41], key_in[49],
                    key_in[57], key_in[2],  key_in[10], key_in[18], key_in[26], key_in[34], key_in[42],
                    key_in[50], key_in[58], key_in[3],  key_in[11], key_in[19], key_in[27], key_in[35],
                    key_in[43], key_in[51], key_in[59], key_in[36], key_in[44], key_in[52], key_in[60]};

    // The eight parity bits take no part in the schedule.
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    // Encrypt advances to round rnd+2; decrypt walks back from round 16-rnd.
    assign enc_round = {1'b0, rnd_q} + 5'd2;
    assign dec_round = 5'd16 - {1'b0, rnd_q};

    // Next C/D halves for a normal round step.
    always_comb begin
        c_step = rotl(c_q, sched_two(enc_round));
        d_step = rotl(d_q, sched_two(enc_round));
        if (mode_q) begin
            c_step = rotr(c_q, sched_two(dec_round));
            d_step = rotr(d_q, sched_two(dec_round));
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state: load always (re)starts a run, round 15 ends it.
    always_comb begin
        state_nxt = state;
        if (load)                                  state_nxt = RUN;
        else if ((state == RUN) && (rnd_q == 4'd15)) state_nxt = IDLE;
    end

    // Key halves, round counter, mode latch and sticky sync flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q    <= '0;
            d_q    <= '0;
            rnd_q  <= '0;
            mode_q <= 1'b0;
            sync_q <= 1'b0;
        end else if (load) begin
            mode_q <= decrypt;
            rnd_q  <= '0;
            sync_q <= 1'b0;
            c_q    <= decrypt ? pc1_c : rotl(pc1_c, 1'b0);
            d_q    <= decrypt ? pc1_d : rotl(pc1_d, 1'b0);
        end else if (state == RUN) begin
            if (cnt_in != (4'd15 - rnd_q)) sync_q <= 1'b1;
            if (rnd_q != 4'd15) begin
                rnd_q <= rnd_q + 4'd1;
                c_q   <= c_step;
                d_q   <= d_step;
            end
        end
    end

    // FSM outputs: PC-2 of the current halves, gated to zero when idle.
    always_comb begin
        subkey       = '0;
        subkey_valid = 1'b0;
        last_key     = 1'b0;
        if (state == RUN) begin
            subkey_valid = 1'b1;
            last_key     = (rnd_q == 4'd15);
            subkey = {c_q[14], c_q[11], c_q[17], c_q[4],  c_q[27], c_q[23],
                      c_q[25], c_q[0],  c_q[13], c_q[22], c_q[7],  c_q[18],
                      c_q[5],  c_q[9],  c_q[16], c_q[24], c_q[2],  c_q[20],
                      c_q[12], c_q[21], c_q[1],  c_q[8],  c_q[15], c_q[26],
                      d_q[15], d_q[4],  d_q[25], d_q[19], d_q[9],  d_q[1],
                      d_q[26], d_q[16], d_q[5],  d_q[11], d_q[23], d_q[8],
                      d_q[12], d_q[7],  d_q[17], d_q[0],  d_q[22], d_q[3],
                      d_q[10], d_q[14], d_q[6],  d_q[20], d_q[27], d_q[24]};
        end
    end

    assign round_idx = rnd_q;
    assign sync_err  = sync_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known-answer and reference-model key
// sequences, restart, desync and asynchronous reset scenarios.
`timescale 1ns/1ps

module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [63:0] key_in;
    logic        decrypt;
    logic [3:0]  cnt_in;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        last_key;
    logic        sync_err;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .cnt_in       (cnt_in),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round_idx    (round_idx),
        .last_key     (last_key),
        .sync_err     (sync_err)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] KNOWN = 64'h133457799BBCDFF1;

    localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Published schedule K1..K16 for the key 133457799BBCDFF1.
    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

    typedef struct {
        logic [47:0] key;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic [47:0] k_first;
        logic [47:0] k_last;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int          n_pass = 0;
    int          n_total = 0;
    logic        exp_sync = 1'b0;
    logic [3:0]  cnt_ref = 4'd15;

    // Subkey of 0-based round r computed from scratch: PC-1, cumulative
    // left rotation, PC-2.
    function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
        logic [27:0] c, d;
        logic [63:0] t;
        logic [55:0] cd, u;
        logic [47:0] o;
        int total;
        c = '0; d = '0; o = '0; total = 0;
        for (int i = 0; i < 28; i++) begin
            t = k >> (64 - PC1[i]);
            c = {c[26:0], t[0]};
        end
        for (int i = 28; i < 56; i++) begin
            t = k >> (64 - PC1[i]);
            d = {d[26:0], t[0]};
        end
        for (int j = 0; j <= r; j++) total += SHIFTS[j];
        for (int j = 0; j < total; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) begin
            u = cd >> (56 - PC2[i]);
            o = {o[46:0], u[0]};
        end
        return o;
    endfunction

    // Expected key shown at position p (0..15) of a run.
    function automatic logic [47:0] exp_key(input logic [63:0] k, input logic dec, input int p);
        int r;
        r = dec ? 15 - p : p;
        if (k == KNOWN) return KS[r];
        return ref_key(k, r);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, req);
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("valid", 64'(subkey_valid), 64'd1);
            chk("subkey", 64'(subkey), 64'(e.key));
            chk("round_idx", 64'(round_idx), 64'(e.idx));
            chk("last_key", 64'(last_key), 64'(e.last));
        end else begin
            chk("idle_valid", 64'(subkey_valid), 64'd0);
            chk("idle_subkey", 64'(subkey), 64'd0);
            chk("idle_last", 64'(last_key), 64'd0);
        end
        chk("sync_err", 64'(sync_err), 64'(exp_sync));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Load a key; the external counter is set on the same edge.
    task automatic start(input logic [63:0] k, input logic dec);
        exp_t e;
        load    = 1'b1;
        key_in  = k;
        decrypt = dec;
        cnt_in  = 4'($urandom_range(0, 15));
        sb.delete();
        for (int p = 0; p < 16; p++) begin
            e.key  = exp_key(k, dec, p);
            e.idx  = 4'(p);
            e.last = (p == 15);
            sb.push_back(e);
        end
        exp_sync = 1'b0;
        cycle();
        load    = 1'b0;
        key_in  = {$urandom(), $urandom()};
        decrypt = ~dec;
        cnt_ref = 4'd15;
    endtask

    task automatic advance();
        cnt_in = cnt_ref;
        cycle();
        cnt_ref = cnt_ref - 4'd1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cnt_in = 4'($urandom_range(0, 15));
            cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{KNOWN, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[1] = '{KNOWN, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
        vecs[2] = '{64'h0123456789ABCDEF, 1'b0, ref_key(64'h0123456789ABCDEF, 0), ref_key(64'h0123456789ABCDEF, 15)};
        vecs[3] = '{64'h0123456789ABCDEF, 1'b1, ref_key(64'h0123456789ABCDEF, 15), ref_key(64'h0123456789ABCDEF, 0)};
        vecs[4] = '{64'hFEDCBA9876543210, 1'b0, ref_key(64'hFEDCBA9876543210, 0), ref_key(64'hFEDCBA9876543210, 15)};
        vecs[5].key = {$urandom(), $urandom()};
        vecs[5].dec = 1'b1;
        vecs[5].k_first = ref_key(vecs[5].key, 15);
        vecs[5].k_last  = ref_key(vecs[5].key, 0);

        // Reset state, and a load while in reset is ignored.
        rst = 1'b1; load = 1'b0; key_in = KNOWN; decrypt = 1'b0; cnt_in = 4'd0;
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_subkey", 64'(subkey), 64'd0);
        chk("rst_round_idx", 64'(round_idx), 64'd0);
        chk("rst_last", 64'(last_key), 64'd0);
        chk("rst_sync", 64'(sync_err), 64'd0);
        load = 1'b1;
        cycle();
        load = 1'b0;
        #3 rst = 1'b1;
        idle_cycles(3);

        // Table-driven full runs.
        for (int v = 0; v < 6; v++) begin
            start(vecs[v].key, vecs[v].dec);
            chk("table_first", 64'(subkey), 64'(vecs[v].k_first));
            for (int i = 0; i < 15; i++) advance();
            chk("table_last", 64'(subkey), 64'(vecs[v].k_last));
            advance();
            idle_cycles(2);
        end

        // Restart: second load five cycles after the first.
        start(KNOWN, 1'b0);
        for (int i = 0; i < 4; i++) advance();
        chk("pre_restart_idx", 64'(round_idx), 64'd4);
        start(64'h0123456789ABCDEF, 1'b0);
        chk("restart_idx", 64'(round_idx), 64'd0);
        for (int i = 0; i < 15; i++) advance();
        chk("restart_last", 64'(last_key), 64'd1);
        advance();
        idle_cycles(2);

        // Desync: wrong counter value while round 3 is shown.
        start(KNOWN, 1'b0);
        for (int i = 0; i < 3; i++) advance();
        cnt_in = 4'd7;
        exp_sync = 1'b1;
        cycle();
        cnt_ref = cnt_ref - 4'd1;
        for (int i = 0; i < 12; i++) advance();
        idle_cycles(3);
        start(KNOWN, 1'b1);
        chk("sync_cleared", 64'(sync_err), 64'd0);
        for (int i = 0; i < 16; i++) advance();

        // Asynchronous reset in the middle of a run.
        start(KNOWN, 1'b0);
        for (int i = 0; i < 8; i++) advance();
        #2 rst = 1'b0;
        #1;
        sb.delete();
        exp_sync = 1'b0;
        chk("midrst_valid", 64'(subkey_valid), 64'd0);
        chk("midrst_subkey", 64'(subkey), 64'd0);
        chk("midrst_round_idx", 64'(round_idx), 64'd0);
        chk("midrst_last", 64'(last_key), 64'd0);
        idle_cycles(2);
        #3 rst = 1'b1;
        idle_cycles(4);
        start(KNOWN, 1'b0);
        for (int i = 0; i < 16; i++) advance();
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
